matvec_acc: RTL and testbench

MATVEC_ACC -- requirements
Module: matvec_acc

---
 rtl/matvec_acc.sv | 192 +++++++++++++++++++
 tb/tb_matvec_acc.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matvec_acc.sv
`default_nettype none
// ============================================================================
// Module   : matvec_acc
// Purpose  : Tiled signed matrix-vector multiply-accumulate. Each accepted
//            beat carries an R x C matrix tile k and a C-element vector tile
//            x. Per-row products feed a registered binary adder tree, and
//            the tile sums accumulate until the last tile of a vector.
//            The finished per-row dot products are then presented on y.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk      in   1        rising-edge clock
//   rstn     in   1        asynchronous active-low reset
//   s_valid  in   1        input tile beat valid
//   s_ready  out  1        block accepts a tile beat this cycle
//   s_last   in   1        beat is the final tile of the current vector
//   k        in   R*C*W_K  signed matrix tile, element (r,c) at (r*C+c)*W_K
//   x        in   C*W_X    signed vector tile, element c at c*W_X
//   m_valid  out  1        result y valid
//   m_ready  in   1        downstream accepts y
//   y        out  R*W_Y    signed per-row dot products, row r at r*W_Y
//   err      out  1        sticky tile-overrun flag
// ============================================================================
module matvec_acc #(
  parameter int R       = 8,
  parameter int C       = 8,
  parameter int W_X     = 8,
  parameter int W_K     = 8,
  parameter int N_TILES = 4,
  localparam int DEPTH  = $clog2(C),
  localparam int W_T    = W_X + W_K + DEPTH,
  localparam int W_Y    = W_T + $clog2(N_TILES) + 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               s_last,
  input  logic [R*C*W_K-1:0] k,
  input  logic [C*W_X-1:0]   x,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [R*W_Y-1:0]   y,
  output logic               err
);

  localparam int C_PAD = 1 << DEPTH;
  // Heap-ordered tree: node i has children 2i+1 and 2i+2; leaves start at C_PAD-1.
  localparam int NODES = 2 * C_PAD - 1;
  localparam int CW    = (N_TILES > 1) ? $clog2(N_TILES) : 1;

  logic                 ready_q, ready_d;
  logic                 in_vld_q, in_vld_d;
  logic                 in_lst_q, in_lst_d;
  logic [R*C*W_K-1:0]   k_q, k_d;
  logic [C*W_X-1:0]     x_q, x_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [DEPTH:0]       vld_q, vld_d;
  logic [DEPTH:0]       lst_q, lst_d;
  logic signed [W_T-1:0] tree_q [R][NODES];
  logic signed [W_T-1:0] tree_d [R][NODES];
  logic signed [W_Y-1:0] acc_q [R];
  logic signed [W_Y-1:0] acc_d [R];
  logic signed [W_Y-1:0] y_q [R];
  logic signed [W_Y-1:0] y_d [R];
  logic                 m_valid_q, m_valid_d;

  logic en;
  logic accept;

  // The whole datapath advances only when the output slot is free or draining.
  assign en      = !m_valid_q || m_ready;
  // ready_q keeps s_ready low through reset and for the first edge after it.
  assign s_ready = ready_q && en;
  assign accept  = s_valid && s_ready;
  assign m_valid = m_valid_q;
  assign err     = err_q;

  always_comb begin
    y = '0;
    for (int r = 0; r < R; r++) begin
      y[r*W_Y +: W_Y] = y_q[r];
    end
  end

  always_comb begin
    logic signed [W_Y-1:0] sum;
    sum       = '0;
    ready_d   = 1'b1;
    in_vld_d  = in_vld_q;
    in_lst_d  = in_lst_q;
    k_d       = k_q;
    x_d       = x_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    vld_d     = vld_q;
    lst_d     = lst_q;
    tree_d    = tree_q;
    acc_d     = acc_q;
    y_d       = y_q;
    m_valid_d = m_valid_q;

    // Tile counting. The N_TILES-th beat closes the vector even without
    // s_last so a missing terminator cannot grow the accumulator unbounded.
    if (accept) begin
      k_d = k;
      x_d = x;
      if (s_last || cnt_q == CW'(N_TILES - 1)) begin
        cnt_d = '0;
        if (!s_last) begin
          err_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (en) begin
      in_vld_d = accept;
      in_lst_d = accept && (s_last || cnt_q == CW'(N_TILES - 1));

      vld_d = {vld_q[DEPTH-1:0], in_vld_q};
      lst_d = {lst_q[DEPTH-1:0], in_lst_q};

      for (int r = 0; r < R; r++) begin
        for (int c = 0; c < C; c++) begin
          tree_d[r][C_PAD-1+c] = W_T'($signed(k_q[(r*C+c)*W_K +: W_K]))
                               * W_T'($signed(x_q[c*W_X +: W_X]));
        end
        for (int c = C; c < C_PAD; c++) begin
          tree_d[r][C_PAD-1+c] = '0;
        end
        for (int i = 0; i < C_PAD - 1; i++) begin
          tree_d[r][i] = tree_q[r][2*i+1] + tree_q[r][2*i+2];
        end
      end

      // Accumulate the tree root; a last tile flushes to y and restarts at 0.
      m_valid_d = vld_q[DEPTH] && lst_q[DEPTH];
      if (vld_q[DEPTH]) begin
        for (int r = 0; r < R; r++) begin
          sum = acc_q[r] + W_Y'(tree_q[r][0]);
          if (lst_q[DEPTH]) begin
            y_d[r]   = sum;
            acc_d[r] = '0;
          end else begin
            acc_d[r] = sum;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ready_q   <= 1'b0;
      in_vld_q  <= 1'b0;
      in_lst_q  <= 1'b0;
      k_q       <= '0;
      x_q       <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      vld_q     <= '0;
      lst_q     <= '0;
      m_valid_q <= 1'b0;
      for (int r = 0; r < R; r++) begin
        for (int i = 0; i < NODES; i++) begin
          tree_q[r][i] <= '0;
        end
        acc_q[r] <= '0;
        y_q[r]   <= '0;
      end
    end else begin
      ready_q   <= ready_d;
      in_vld_q  <= in_vld_d;
      in_lst_q  <= in_lst_d;
      k_q       <= k_d;
      x_q       <= x_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      vld_q     <= vld_d;
      lst_q     <= lst_d;
      m_valid_q <= m_valid_d;
      tree_q    <= tree_d;
      acc_q     <= acc_d;
      y_q       <= y_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matvec_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_matvec_acc
// Purpose  : Directed self-checking bench for matvec_acc (R=2, C=3 padded to
//            4, N_TILES=2). Expected results come from a behavioural model and
//            are queued at beat acceptance, then popped when y is delivered.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matvec_acc;

  localparam int R       = 2;
  localparam int C       = 3;
  localparam int W_X     = 8;
  localparam int W_K     = 8;
  localparam int N_TILES = 2;
  localparam int W_Y     = 20;  // (8+8+2) + 1 + 1
  localparam int L       = 4;   // clog2(3) + 2

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               s_valid = 1'b0;
  logic               s_last = 1'b0;
  logic               m_ready = 1'b1;
  logic               s_ready;
  logic               m_valid;
  logic               err;
  logic [R*C*W_K-1:0] k = '0;
  logic [C*W_X-1:0]   x = '0;
  logic [R*W_Y-1:0]   y;

  always #5 clk = ~clk;

  matvec_acc #(
    .R(R), .C(C), .W_X(W_X), .W_K(W_K), .N_TILES(N_TILES)
  ) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready),
    .s_last(s_last), .k(k), .x(x), .m_valid(m_valid), .m_ready(m_ready),
    .y(y), .err(err)
  );

  int total = 0;
  int bad   = 0;

  int      kv [R][C];
  int      xv [C];
  longint  macc [R];
  int      mcnt = 0;
  bit      exp_err = 1'b0;
  logic [R*W_Y-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < R; r++) macc[r] = 0;
    mcnt = 0;
  endtask

  task automatic model_accept(input bit last);
    logic [R*W_Y-1:0] e;
    longint lm;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        macc[r] += longint'(kv[r][c]) * longint'(xv[c]);
    mcnt++;
    if (last || mcnt == N_TILES) begin
      if (!last) exp_err = 1'b1;
      e = '0;
      for (int r = 0; r < R; r++) begin
        lm = macc[r];
        e[r*W_Y +: W_Y] = lm[W_Y-1:0];
      end
      exp_q.push_back(e);
      model_clear();
    end
  endtask

  task automatic fill(input int kval, input int xval);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) kv[r][c] = kval;
    for (int c = 0; c < C; c++) xv[c] = xval;
  endtask

  task automatic rand_tile();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) kv[r][c] = int'($urandom_range(255)) - 128;
    for (int c = 0; c < C; c++) xv[c] = int'($urandom_range(255)) - 128;
  endtask

  // Presents one beat from the next falling edge and returns after the
  // accepting rising edge; waited counts cycles stalled by s_ready.
  task automatic send(input bit last, output int waited);
    int t;
    waited = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_last  = last;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        t = kv[r][c];
        k[(r*C+c)*W_K +: W_K] = t[W_K-1:0];
      end
    for (int c = 0; c < C; c++) begin
      t = xv[c];
      x[c*W_X +: W_X] = t[W_X-1:0];
    end
    while (!s_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("send_ready", 64'(s_ready), 64'd1);
    if (s_ready) model_accept(last);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    model_clear();
    exp_err = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_y", 64'(y), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rstn = 1'b1;
    #1;
    chk("s_ready_before_edge", 64'(s_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("s_ready_after_edge", 64'(s_ready), 64'd1);
  endtask

  // Scoreboard: every delivered result must match the oldest expected one.
  always @(negedge clk) begin
    if (rstn && m_valid && m_ready) begin
      chk("result_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) chk("y", 64'(y), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    int w;
    int n;
    bit held;
    logic [R*W_Y-1:0] ys;

    do_reset();

    // Single tile: latency and one-cycle pulse. Expected 1+2+3 per row.
    fill(1, 0);
    xv[0] = 1; xv[1] = 2; xv[2] = 3;
    send(1'b1, w);
    for (int i = 1; i < L; i++) begin
      @(posedge clk);
      #1;
      chk("latency_early", 64'(m_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    chk("latency_due", 64'(m_valid), 64'd1);
    chk("single_row0", 64'(y[W_Y-1:0]), 64'd6);
    @(posedge clk);
    #1;
    chk("single_pulse", 64'(m_valid), 64'd0);

    // Two tiles, row1 negative: expected {9, -9}.
    fill(1, 1);
    for (int c = 0; c < C; c++) kv[1][c] = -1;
    send(1'b0, w);
    fill(1, 2);
    for (int c = 0; c < C; c++) kv[1][c] = -1;
    send(1'b1, w);
    drain();

    // Most negative operands with padded column: 3 * 16384 per row.
    fill(-128, -128);
    send(1'b1, w);
    n = 0;
    while (!m_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("neg128_row0", 64'(y[W_Y-1:0]), 64'd49152);
    chk("neg128_row1", 64'(y[2*W_Y-1:W_Y]), 64'd49152);
    drain();

    // Backpressure: results held while streaming continues to stall.
    m_ready = 1'b0;
    held = 1'b0;
    ys = '0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          rand_tile();
          send(i % 2 == 1, w);
        end
      end
      begin
        repeat (10) begin
          @(negedge clk);
          if (m_valid) begin
            if (!held) begin
              held = 1'b1;
              ys = y;
            end else begin
              chk("bp_y_stable", 64'(y), 64'(ys));
              chk("bp_s_ready_low", 64'(s_ready), 64'd0);
            end
          end
        end
        chk("bp_result_held", 64'(held), 64'd1);
        m_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-vector discards the partial sum.
    rand_tile();
    send(1'b0, w);
    do_reset();
    repeat (L + 2) @(posedge clk);
    #1;
    chk("no_result_after_reset", 64'(m_valid), 64'd0);
    fill(2, 3);
    send(1'b1, w);
    drain();

    // Overrun: second beat without s_last closes the vector and sets err.
    chk("err_clear", 64'(err), 64'd0);
    rand_tile(); send(1'b0, w);
    rand_tile(); send(1'b0, w);
    chk("err_on_overrun", 64'(err), 64'd1);
    rand_tile(); send(1'b0, w);
    rand_tile(); send(1'b1, w);
    drain();
    chk("err_model", 64'(err), 64'(exp_err));

    // Back-to-back stream: no stalls between vectors.
    for (int i = 0; i < 16; i++) begin
      rand_tile();
      send((i == 15) ? 1'b1 : 1'($urandom_range(1)), w);
      chk("no_dead_cycle", 64'(w), 64'd0);
    end
    drain();
    chk("err_sticky", 64'(err), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
